// File: rtl/fpdp_rcprcl_arbiter.sv
// fpdp_rcprcl_arbiter
// Shares one double-precision reciprocal unit between N_REQ requesters.
// Requesters are granted round-robin. The winning operand is latched and
// launched into the unit. The arbiter then waits for completion and returns
// the result with a one-cycle ack. If the unit never answers within TIMEOUT
// wait cycles, the operation is aborted and a quiet NaN is returned with err.
//
// Ports
//   clk         sole clock, all logic on posedge
//   rset        synchronous active-high reset
//   req         per-requester level request, held until its ack
//   req_data    64-bit operand per requester, slot i at [64i+63:64i]
//   ack         one-hot, one-cycle pulse to the served requester
//   result      reciprocal result (or quiet NaN on abort), valid with ack
//   err         1 = timeout abort, valid with ack
//   busy        high whenever the arbiter is not idle
//   rcp_input   operand driven to the reciprocal unit
//   rcp_ready   unit enable code: 4'd2 run, 4'd0 hold
//   rcp_done    unit status: 4'd3 result available
//   rcp_output  unit result
module fpdp_rcprcl_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 1023,
  parameter int GUARD   = 2
) (
  input  logic                 clk,
  input  logic                 rset,
  input  logic [N_REQ-1:0]     req,
  input  logic [64*N_REQ-1:0]  req_data,
  output logic [N_REQ-1:0]     ack,
  output logic [63:0]          result,
  output logic                 err,
  output logic                 busy,
  output logic [63:0]          rcp_input,
  output logic [3:0]           rcp_ready,
  input  logic [3:0]           rcp_done,
  input  logic [63:0]          rcp_output
);

  localparam int IW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  // Counter must represent both the guard window and the timeout limit.
  localparam int CNT_LIM  = (TIMEOUT > GUARD) ? TIMEOUT : GUARD;
  localparam int CW       = (CNT_LIM > 1) ? $clog2(CNT_LIM + 1) : 1;
  localparam int TO_LAST  = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;

  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE   = CW'(1'b1);
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] GUARD_C   = CW'(GUARD);
  localparam logic [CW-1:0] TO_LAST_C = CW'(TO_LAST);

  localparam logic [63:0] QNAN      = 64'h7FF8_0000_0000_0000;
  localparam logic [3:0]  RDY_RUN   = 4'd2;
  localparam logic [3:0]  RDY_HOLD  = 4'd0;
  localparam logic [3:0]  UNIT_DONE = 4'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RETURN = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [IW-1:0]     ptr_r;
  logic [IW-1:0]     winner_r;
  logic [IW-1:0]     grant_idx_s;
  logic              grant_vld_s;
  logic [63:0]       sel_data_s;
  logic [CW-1:0]     cnt_r;
  logic [CW-1:0]     cnt_inc_s;
  logic              done_ok_s;
  logic              timeout_s;

  logic [N_REQ-1:0]  ack_r;
  logic [63:0]       result_r;
  logic              err_r;
  logic              busy_r;
  logic [63:0]       rcp_input_r;
  logic [3:0]        rcp_ready_r;

  // Index 'off' positions after 'base', wrapping modulo N_REQ.
  function automatic logic [IW-1:0] rr_index(input logic [IW-1:0] base, input int off);
    return IW'((int'(base) + off) % N_REQ);
  endfunction

  // One-hot decode of a requester index.
  function automatic logic [N_REQ-1:0] onehot(input logic [IW-1:0] idx);
    logic [N_REQ-1:0] v;
    v = {N_REQ{1'b0}};
    for (int j = 0; j < N_REQ; j++) begin
      v[j] = (idx == IW'(j));
    end
    return v;
  endfunction

  // Round-robin search: first requesting index at or after ptr_r.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_idx_s = {IW{1'b0}};
    for (int k = 0; k < N_REQ; k++) begin
      grant_idx_s = (!grant_vld_s && req[rr_index(ptr_r, k)]) ? rr_index(ptr_r, k) : grant_idx_s;
      grant_vld_s = grant_vld_s | req[rr_index(ptr_r, k)];
    end
  end

  // Operand mux for the granted requester.
  always_comb begin
    sel_data_s = 64'd0;
    for (int j = 0; j < N_REQ; j++) begin
      sel_data_s = (grant_idx_s == IW'(j)) ? req_data[64*j +: 64] : sel_data_s;
    end
  end

  // Wait-phase qualifiers; a qualifying done wins over a simultaneous timeout.
  always_comb begin
    cnt_inc_s = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CNT_ONE);
    done_ok_s = (state_r == ST_WAIT) && (cnt_r >= GUARD_C) && (rcp_done == UNIT_DONE);
    timeout_s = (state_r == ST_WAIT) && (cnt_r >= TO_LAST_C);
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_vld_s) begin
          state_nxt_s = ST_LAUNCH;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LAUNCH: state_nxt_s = ST_WAIT;
      ST_WAIT: begin
        if (done_ok_s || timeout_s) begin
          state_nxt_s = ST_RETURN;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_RETURN: state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Grant latch, wait counter, result capture and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rset) begin
      ptr_r       <= {IW{1'b0}};
      winner_r    <= {IW{1'b0}};
      rcp_input_r <= 64'd0;
      cnt_r       <= CNT_ZERO;
      result_r    <= 64'd0;
      err_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // Operand is captured here so later req_data changes cannot leak in.
          if (grant_vld_s) begin
            winner_r    <= grant_idx_s;
            rcp_input_r <= sel_data_s;
          end
        end
        ST_LAUNCH: cnt_r <= CNT_ZERO;
        ST_WAIT: begin
          cnt_r <= cnt_inc_s;
          if (done_ok_s) begin
            result_r <= rcp_output;
            err_r    <= 1'b0;
          end else if (timeout_s) begin
            result_r <= QNAN;
            err_r    <= 1'b1;
          end
        end
        ST_RETURN: ptr_r <= rr_index(winner_r, 1);
        default: begin
          cnt_r <= CNT_ZERO;
        end
      endcase
    end
  end

  // Registered outputs derived from the state being entered, so they line up
  // with the state register.
  always_ff @(posedge clk) begin
    if (rset) begin
      ack_r       <= {N_REQ{1'b0}};
      busy_r      <= 1'b0;
      rcp_ready_r <= RDY_HOLD;
    end else begin
      ack_r       <= (state_nxt_s == ST_RETURN) ? onehot(winner_r) : {N_REQ{1'b0}};
      busy_r      <= (state_nxt_s != ST_IDLE);
      rcp_ready_r <= ((state_nxt_s == ST_LAUNCH) || (state_nxt_s == ST_WAIT)) ? RDY_RUN : RDY_HOLD;
    end
  end

  assign ack       = ack_r;
  assign result    = result_r;
  assign err       = err_r;
  assign busy      = busy_r;
  assign rcp_input = rcp_input_r;
  assign rcp_ready = rcp_ready_r;

endmodule

// File: doc/fpdp_rcprcl_arbiter.md
FPDP_RCPRCL_ARBITER -- requirements
Module: fpdp_rcprcl_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters sharing one reciprocal unit.
REQ-002 SHALL have parameter TIMEOUT, default 1023, maximum WAIT cycles before abort.
REQ-003 SHALL have parameter GUARD, default 2, cycles after launch during which rcp_done is ignored.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on posedge.
REQ-005 SHALL have port rset  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port req  input  N_REQ  per-requester level request; held until matching ack.
REQ-007 SHALL have port req_data  input  64*N_REQ  IEEE-754 double operand per requester, slot i at [64i+63:64i].
REQ-008 SHALL have port ack  output  N_REQ  one-hot one-cycle pulse to the served requester.
REQ-009 SHALL have port result  output  64  reciprocal result, valid in the ack cycle.
REQ-010 SHALL have port err  output  1  valid with ack; 1 = timeout abort, result forced to 64'h7FF8000000000000.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port rcp_input  output  64  operand to the reciprocal unit.
REQ-013 SHALL have port rcp_ready  output  4  unit enable code: 4'd2 = run, 4'd0 = hold.
REQ-014 SHALL have port rcp_done  input  4  unit status; 4'd3 = result available.
REQ-015 SHALL have port rcp_output  input  64  unit result.

Function
REQ-016 SHALL implement FSM IDLE -> LAUNCH -> WAIT -> RETURN -> IDLE, one transition per clock maximum.
REQ-017 IDLE SHALL, when any req bit is set, grant by round-robin starting from index ptr, latch the winner index and its req_data, and go to LAUNCH; with req == 0 it SHALL stay in IDLE.
REQ-018 LAUNCH SHALL drive rcp_input with the latched operand, set rcp_ready = 4'd2, clear the wait counter, and go to WAIT next cycle.
REQ-019 WAIT SHALL keep rcp_ready = 4'd2 and rcp_input stable, increment a wait counter each cycle, and ignore rcp_done while counter < GUARD.
REQ-020 WAIT SHALL, when counter >= GUARD and rcp_done == 4'd3, capture rcp_output into result, clear err, and go to RETURN.
REQ-021 WAIT SHALL, when the counter reaches TIMEOUT without a qualifying rcp_done, load the quiet-NaN constant into result, set err, and go to RETURN; done seen in the same cycle takes priority over timeout.
REQ-022 RETURN SHALL pulse ack[winner] for exactly one cycle, drive rcp_ready = 4'd0, set ptr = (winner + 1) mod N_REQ, and go to IDLE.
REQ-023 rcp_ready SHALL be 4'd0 in IDLE and RETURN; the unit is never enabled for two requesters at once.
REQ-024 result and err SHALL hold their value until the next RETURN; ack SHALL be 0 outside RETURN.
REQ-025 Requester deasserting req after grant SHALL NOT abort the operation; the ack is still issued.
REQ-026 Changes to req_data after grant SHALL NOT affect rcp_input for the current operation.
REQ-027 A requester acked in RETURN with req still high SHALL be eligible again only after all other pending requesters are served (round-robin fairness).
REQ-028 Wait counter SHALL be wide enough for TIMEOUT and SHALL saturate, never wrap.

Reset
REQ-029 rset high at any clock edge SHALL force IDLE, ptr = 0, ack = 0, busy = 0, err = 0, result = 64'd0, rcp_ready = 4'd0, rcp_input = 64'd0, counter = 0, overriding every other condition.
REQ-030 Reset mid-operation SHALL discard the in-flight operation without ack; the next operation restarts from LAUNCH.

Verification
REQ-031 Single request: req = 4'b0001, req_data[63:0] = 64'h4000000000000000, unit returns 64'h3FE0000000000000 -> ack = 4'b0001 one cycle, result = 64'h3FE0000000000000, err = 0.
REQ-032 Contention: req = 4'b1111 held, each operand distinct -> acks in order 0,1,2,3,0 with matching results; no rcp_ready = 2 overlap between operations.
REQ-033 Stale done: rcp_done = 4'd3 already high at launch -> no completion before GUARD cycles; completion on first qualifying cycle after.
REQ-034 Timeout: rcp_done held 4'd0 -> ack after TIMEOUT WAIT cycles with err = 1, result = 64'h7FF8000000000000.
REQ-035 Reset in WAIT: rset pulsed one cycle -> busy = 0 and rcp_ready = 4'd0 next cycle, no ack; pending request then re-granted starting from index 0.
REQ-036 Late req drop: req[2] dropped in WAIT -> ack[2] still pulses with correct result.
